// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN-order elevator scheduler with door dwell, request latching and idle homing.
// Drives floor/door/status outputs for the SmartLift board; all outputs are registered.
module lift_scheduler #(
    parameter int N_FLOORS   = 9,
    parameter int HOME_FLOOR = 0,
    parameter int DOOR_TICKS = 2,
    parameter int IDLE_TICKS = 5
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                step_tick,
    input  logic                req_stb,
    input  logic [N_FLOORS-1:0] req_sw,
    output logic [3:0]          cur_floor,
    output logic [1:0]          estado_atual,
    output logic                door_open,
    output logic                door_closed,
    output logic [N_FLOORS-1:0] pending,
    output logic                lcd_reset,
    output logic                req_err
);
    typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, INATIVO} state_t;
    localparam logic [3:0] TOP = 4'(N_FLOORS - 1);
    localparam logic [3:0] HOME = 4'(HOME_FLOOR);
    localparam logic [7:0] DOOR = 8'(DOOR_TICKS);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);
    localparam logic [N_FLOORS-1:0] ONE = {{(N_FLOORS-1){1'b0}}, 1'b1};
    state_t state, n_state;
    logic [3:0] n_floor, req_idx, step_floor;
    logic [7:0] door_cnt, n_door, idle_cnt, n_idle;
    logic dir_up, n_dir, one_hot, same, accept, above, below;
    logic [N_FLOORS-1:0] new_mask, n_pend, cur_bit, step_bit;
    assign one_hot = (req_sw != '0) && ((req_sw & (req_sw - ONE)) == '0);
    assign same = req_stb && one_hot && req_idx == cur_floor && state == PARADO;
    assign accept = req_stb && one_hot && !same;
    assign new_mask = pending | (accept ? req_sw : '0);
    assign cur_bit = ONE << cur_floor;
    assign above = |(new_mask & ~((cur_bit << 1) - ONE));
    assign below = |(new_mask & (cur_bit - ONE));
    assign step_floor = state == SUBINDO ? (cur_floor == TOP ? TOP : cur_floor + 4'd1)
                                         : (cur_floor == 4'd0 ? 4'd0 : cur_floor - 4'd1);
    assign step_bit = ONE << step_floor;
    assign estado_atual = state;
    always_comb begin
        req_idx = '0;
        for (int i = 0; i < N_FLOORS; i++) if (req_sw[i]) req_idx = 4'(i);
    end
    // A request for the floor the car is parked at only restarts the dwell.
    always_comb begin
        n_state = state;
        n_floor = cur_floor;
        n_pend = new_mask;
        n_dir = dir_up;
        n_door = same ? 8'd0 : door_cnt;
        n_idle = (same || accept) ? 8'd0 : idle_cnt;
        if (step_tick && !same) begin
            case (state)
                PARADO:
                    if (door_cnt < DOOR) n_door = door_cnt + 8'd1;
                    else if (dir_up && above) n_state = SUBINDO;
                    else if (below) begin
                        n_state = DESCENDO;
                        n_dir = 1'b0;
                    end else if (above) begin
                        n_state = SUBINDO;
                        n_dir = 1'b1;
                    end else if (cur_floor != HOME) begin
                        n_idle = idle_cnt + 8'd1;
                        if (idle_cnt == IDLE_LAST) begin
                            n_state = INATIVO;
                            n_idle = 8'd0;
                        end
                    end
                SUBINDO, DESCENDO: begin
                    n_floor = step_floor;
                    if ((new_mask & step_bit) != '0 || step_floor == (state == SUBINDO ? TOP : 4'd0)) begin
                        n_state = PARADO;
                        n_door = 8'd0;
                        n_pend = new_mask & ~step_bit;
                    end
                end
                default:
                    if (new_mask != '0) begin
                        n_state = PARADO;
                        n_door = (new_mask & cur_bit) != '0 ? 8'd0 : DOOR;
                        n_pend = new_mask & ~cur_bit;
                    end else begin
                        n_floor = HOME > cur_floor ? cur_floor + 4'd1 : cur_floor - 4'd1;
                        if (n_floor == HOME) begin
                            n_state = PARADO;
                            n_door = 8'd0;
                        end
                    end
            endcase
        end
    end
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= PARADO;
            cur_floor <= HOME;
            pending <= '0;
            dir_up <= 1'b1;
            door_cnt <= DOOR;
            idle_cnt <= '0;
            door_open <= 1'b1;
            door_closed <= 1'b0;
            lcd_reset <= 1'b0;
            req_err <= 1'b0;
        end else begin
            state <= n_state;
            cur_floor <= n_floor;
            pending <= n_pend;
            dir_up <= n_dir;
            door_cnt <= n_door;
            idle_cnt <= n_idle;
            door_open <= n_state == PARADO;
            door_closed <= n_state != PARADO;
            lcd_reset <= state == PARADO ? (n_state == SUBINDO || n_state == DESCENDO)
                                         : (state != INATIVO && n_state == PARADO);
            req_err <= req_stb && !one_hot;
        end
    end
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios plus randomized traffic against a floor-level behavioural model.
module tb_lift_scheduler;
    localparam int N = 9, HOME = 0, DOOR = 2, IDLE = 5;
    logic CLOCK_50 = 1'b0, RESET = 1'b1, step_tick = 1'b0, req_stb = 1'b0;
    logic [N-1:0] req_sw = '0;
    logic [3:0] cur_floor;
    logic [1:0] estado_atual;
    logic door_open, door_closed, lcd_reset, req_err;
    logic [N-1:0] pending;
    logic [18:0] dut_vec;
    int tests = 0, fails = 0;
    int m_floor, m_state, m_dir, m_door, m_idle;
    bit m_lcd, m_err;
    bit m_pend[N];

    lift_scheduler #(.N_FLOORS(N), .HOME_FLOOR(HOME), .DOOR_TICKS(DOOR), .IDLE_TICKS(IDLE)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .step_tick(step_tick), .req_stb(req_stb), .req_sw(req_sw),
        .cur_floor(cur_floor), .estado_atual(estado_atual), .door_open(door_open), .door_closed(door_closed),
        .pending(pending), .lcd_reset(lcd_reset), .req_err(req_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    assign dut_vec = {cur_floor, estado_atual, door_open, door_closed, pending, lcd_reset, req_err};

    // Model states: 0 stopped, 1 up, 2 down, 3 homing.
    function automatic void model_reset();
        m_floor = HOME; m_state = 0; m_dir = 1; m_door = DOOR; m_idle = 0; m_lcd = 0; m_err = 0;
        for (int f = 0; f < N; f++) m_pend[f] = 0;
    endfunction

    function automatic void model_step(bit stb, logic [N-1:0] sw, bit tick);
        int req = -1, old = m_state, ahead = 0, behind = 0, any = 0;
        bit restart = 0;
        if (stb && $countones(sw) == 1) begin
            for (int f = 0; f < N; f++) if (sw[f]) req = f;
            m_idle = 0;
            if (req == m_floor && m_state == 0) begin restart = 1; m_door = 0; end
            else m_pend[req] = 1;
        end
        m_err = stb && $countones(sw) != 1;
        for (int f = 0; f < N; f++) if (m_pend[f]) begin
            any++;
            if (f > m_floor) ahead++;
            if (f < m_floor) behind++;
        end
        if (tick && !restart) begin
            if (m_state == 0) begin
                if (m_door < DOOR) m_door++;
                else if (m_dir == 1 && ahead > 0) m_state = 1;
                else if (behind > 0) begin m_state = 2; m_dir = 0; end
                else if (ahead > 0) begin m_state = 1; m_dir = 1; end
                else if (m_floor != HOME) begin
                    m_idle++;
                    if (m_idle == IDLE) begin m_state = 3; m_idle = 0; end
                end
            end else if (m_state != 3) begin
                m_floor += (m_state == 1) ? 1 : -1;
                if (m_floor > N - 1) m_floor = N - 1;
                if (m_floor < 0) m_floor = 0;
                if (m_pend[m_floor] || m_floor == (m_state == 1 ? N - 1 : 0)) begin
                    m_pend[m_floor] = 0; m_state = 0; m_door = 0;
                end
            end else if (any > 0) begin
                m_state = 0;
                if (m_pend[m_floor]) begin m_pend[m_floor] = 0; m_door = 0; end
                else m_door = DOOR;
            end else begin
                m_floor += (HOME > m_floor) ? 1 : -1;
                if (m_floor == HOME) begin m_state = 0; m_door = 0; end
            end
        end
        m_lcd = (old == 0 && (m_state == 1 || m_state == 2)) || ((old == 1 || old == 2) && m_state == 0);
    endfunction

    function automatic logic [18:0] exp_vec();
        logic [N-1:0] p = '0;
        for (int f = 0; f < N; f++) p[f] = m_pend[f];
        return {4'(m_floor), 2'(m_state), m_state == 0, m_state != 0, p, m_lcd, m_err};
    endfunction

    function automatic logic [N-1:0] floor_bit(int f);
        logic [N-1:0] v = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    task automatic cyc(input bit stb, input logic [N-1:0] sw, input bit tick);
        req_stb = stb; req_sw = sw; step_tick = tick;
        @(posedge CLOCK_50);
        model_step(stb, sw, tick);
        #1;
        req_stb = 1'b0; req_sw = '0; step_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLOCK_50);
        RESET = 1'b1;
        model_reset();
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, i[0]);
            tests++;
            if (dut_vec !== {4'd0, 2'd0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0}) begin
                fails++; $display("FAIL reset_state cyc=%0d got=%h want=%h", i, dut_vec, {4'd0, 2'd0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        cyc(1, floor_bit(5), 0);
        tests++;
        if (pending !== 9'h020) begin fails++; $display("FAIL single_latch got=%h want=020", pending); end
        for (int f = 0; f <= 5; f++) begin
            cyc(0, '0, 1);
            tests++;
            if (cur_floor !== 4'(f) || estado_atual !== (f == 5 ? 2'd0 : 2'd1) || lcd_reset !== (f == 0 || f == 5)) begin
                fails++; $display("FAIL single_move f=%0d got floor=%0d st=%0d lcd=%b", f, cur_floor, estado_atual, lcd_reset);
            end
            cyc(0, '0, 0);
            tests++;
            if (lcd_reset !== 1'b0 || dut_vec !== exp_vec()) begin
                fails++; $display("FAIL single_gap f=%0d got=%h want=%h", f, dut_vec, exp_vec());
            end
        end
        tests++;
        if (pending !== 9'h000 || door_open !== 1'b1 || door_closed !== 1'b0) begin
            fails++; $display("FAIL single_arrive got pend=%h door=%b%b want 000 10", pending, door_open, door_closed);
        end
    endtask

    task automatic test_scan();
        apply_reset();
        cyc(1, floor_bit(3), 0);
        cyc(1, floor_bit(7), 0);
        repeat (4) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd3 || estado_atual !== 2'd0 || pending !== 9'h080) begin
            fails++; $display("FAIL scan_stop3 got floor=%0d st=%0d pend=%h want 3 0 080", cur_floor, estado_atual, pending);
        end
        repeat (4) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd4 || estado_atual !== 2'd1) begin
            fails++; $display("FAIL scan_at4 got floor=%0d st=%0d want 4 1", cur_floor, estado_atual);
        end
        cyc(1, floor_bit(1), 0);
        repeat (3) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd7 || estado_atual !== 2'd0 || pending !== 9'h002) begin
            fails++; $display("FAIL scan_stop7 got floor=%0d st=%0d pend=%h want 7 0 002", cur_floor, estado_atual, pending);
        end
        repeat (3) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd7 || estado_atual !== 2'd2 || lcd_reset !== 1'b1) begin
            fails++; $display("FAIL scan_down got floor=%0d st=%0d lcd=%b want 7 2 1", cur_floor, estado_atual, lcd_reset);
        end
        repeat (6) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd1 || estado_atual !== 2'd0 || pending !== 9'h000 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL scan_stop1 got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_same_tick();
        apply_reset();
        cyc(1, floor_bit(8), 0);
        repeat (3) cyc(0, '0, 1);
        cyc(1, floor_bit(3), 1);
        tests++;
        if (cur_floor !== 4'd3 || estado_atual !== 2'd0 || pending !== 9'h100 || lcd_reset !== 1'b1) begin
            fails++; $display("FAIL same_tick got floor=%0d st=%0d pend=%h lcd=%b want 3 0 100 1", cur_floor, estado_atual, pending, lcd_reset);
        end
    endtask

    task automatic test_homing();
        for (int rep = 0; rep < 2; rep++) begin
            apply_reset();
            cyc(1, floor_bit(4), 0);
            repeat (5) cyc(0, '0, 1);
            repeat (6) cyc(0, '0, 1);
            tests++;
            if (cur_floor !== 4'd4 || estado_atual !== 2'd0) begin
                fails++; $display("FAIL home_wait rep=%0d got floor=%0d st=%0d want 4 0", rep, cur_floor, estado_atual);
            end
            cyc(0, '0, 1);
            tests++;
            if (estado_atual !== 2'd3 || lcd_reset !== 1'b0 || door_open !== 1'b0 || door_closed !== 1'b1) begin
                fails++; $display("FAIL home_enter rep=%0d got st=%0d lcd=%b door=%b%b want 3 0 01", rep, estado_atual, lcd_reset, door_open, door_closed);
            end
            if (rep == 0) begin
                for (int f = 3; f >= 0; f--) begin
                    cyc(0, '0, 1);
                    tests++;
                    if (cur_floor !== 4'(f) || estado_atual !== (f == 0 ? 2'd0 : 2'd3) || lcd_reset !== 1'b0) begin
                        fails++; $display("FAIL home_step f=%0d got floor=%0d st=%0d lcd=%b", f, cur_floor, estado_atual, lcd_reset);
                    end
                end
            end else begin
                repeat (2) cyc(0, '0, 1);
                cyc(1, floor_bit(6), 1);
                tests++;
                if (cur_floor !== 4'd2 || estado_atual !== 2'd0 || lcd_reset !== 1'b0 || pending !== 9'h040) begin
                    fails++; $display("FAIL home_abort got floor=%0d st=%0d lcd=%b pend=%h want 2 0 0 040", cur_floor, estado_atual, lcd_reset, pending);
                end
                cyc(0, '0, 1);
                tests++;
                if (estado_atual !== 2'd1 || lcd_reset !== 1'b1) begin
                    fails++; $display("FAIL home_depart got st=%0d lcd=%b want 1 1", estado_atual, lcd_reset);
                end
                repeat (4) cyc(0, '0, 1);
                tests++;
                if (cur_floor !== 4'd6 || estado_atual !== 2'd0) begin
                    fails++; $display("FAIL home_serve got floor=%0d st=%0d want 6 0", cur_floor, estado_atual);
                end
            end
        end
    endtask

    task automatic test_req_err();
        apply_reset();
        cyc(1, 9'h006, 0);
        tests++;
        if (req_err !== 1'b1 || pending !== 9'h000) begin
            fails++; $display("FAIL err_multi got err=%b pend=%h want 1 000", req_err, pending);
        end
        cyc(0, '0, 0);
        tests++;
        if (req_err !== 1'b0) begin fails++; $display("FAIL err_clear got=%b want=0", req_err); end
        cyc(1, 9'h000, 0);
        tests++;
        if (req_err !== 1'b1) begin fails++; $display("FAIL err_zero got=%b want=1", req_err); end
        cyc(1, floor_bit(0), 0);
        tests++;
        if (pending !== 9'h000 || req_err !== 1'b0 || estado_atual !== 2'd0) begin
            fails++; $display("FAIL here_req got pend=%h err=%b st=%0d want 000 0 0", pending, req_err, estado_atual);
        end
        cyc(1, floor_bit(2), 0);
        repeat (2) begin
            cyc(0, '0, 1);
            tests++;
            if (estado_atual !== 2'd0) begin fails++; $display("FAIL dwell_restart got st=%0d want 0", estado_atual); end
        end
        cyc(0, '0, 1);
        tests++;
        if (estado_atual !== 2'd1 || lcd_reset !== 1'b1) begin
            fails++; $display("FAIL dwell_depart got st=%0d lcd=%b want 1 1", estado_atual, lcd_reset);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cyc(1, floor_bit(8), 0);
        repeat (4) cyc(0, '0, 1);
        tests++;
        if (cur_floor !== 4'd3 || estado_atual !== 2'd1) begin
            fails++; $display("FAIL mid_setup got floor=%0d st=%0d want 3 1", cur_floor, estado_atual);
        end
        #5 RESET = 1'b1;
        #1;
        tests++;
        if (cur_floor !== 4'd0 || estado_atual !== 2'd0 || pending !== 9'h000 || door_open !== 1'b1) begin
            fails++; $display("FAIL mid_reset got floor=%0d st=%0d pend=%h door=%b want 0 0 000 1", cur_floor, estado_atual, pending, door_open);
        end
        model_reset();
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            bit stb, tick;
            logic [N-1:0] sw;
            stb = $urandom_range(0, 5) == 0;
            tick = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 7) == 0) sw = N'($urandom);
            else sw = floor_bit(int'($urandom_range(0, N - 1)));
            cyc(stb, sw, tick);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_scan();
        test_same_tick();
        test_homing();
        test_req_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
